// File: rtl/cart_loader_pkg.sv
// cart_loader_pkg: shared constants for the cartridge block loader.
// State encodings, ZPU bridge strobe bit positions, sector geometry and a size check.
package cart_loader_pkg;

   localparam int SECTOR_BYTES = 512;

   // Bit positions inside zpu_out2 / zpu_wr / zpu_rd
   localparam int LBA_SEL = 0;
   localparam int BLK_RD  = 1;
   localparam int BLK_WR  = 2;
   localparam int IO_WR   = 5;
   localparam int DATA_WR = 6;
   localparam int DATA_RD = 2;

   // Loader states (plain constants so legacy tooling can decode them)
   localparam logic [3:0] ST_IDLE = 4'd0;
   localparam logic [3:0] ST_SIZE = 4'd1;
   localparam logic [3:0] ST_LBA  = 4'd2;
   localparam logic [3:0] ST_BLK  = 4'd3;
   localparam logic [3:0] ST_RST  = 4'd4;
   localparam logic [3:0] ST_RD   = 4'd5;
   localparam logic [3:0] ST_PRES = 4'd6;
   localparam logic [3:0] ST_GAP  = 4'd7;
   localparam logic [3:0] ST_DONE = 4'd8;
   localparam logic [3:0] ST_ERR  = 4'd9;

   // A file is loadable when it is non-empty and fits the cart address space.
   function automatic logic size_ok(input logic [31:0] sz, input int addr_w);
      logic [32:0] lim;
      lim = 33'd1 << addr_w;
      return (sz != 32'd0) && ({1'b0, sz} <= lim);
   endfunction

endpackage

// File: rtl/cart_block_loader_if.sv
// cart_block_loader_if: ZPU bridge, cart RAM byte stream and status bundle.
// master = loader side, slave = bridge / cart RAM / host side.
interface cart_block_loader_if #(
   parameter int ADDR_W = 19
);
   logic [7:0]        zpu_in2;
   logic [31:0]       zpu_in3;
   logic [31:0]       zpu_out2;
   logic [31:0]       zpu_out3;
   logic [15:0]       zpu_wr;
   logic [15:0]       zpu_rd;
   logic [ADDR_W-1:0] cart_addr;
   logic [7:0]        cart_data;
   logic              cart_valid;
   logic              cart_ready;
   logic              busy;
   logic              done;
   logic              error;

   modport master (
      input  zpu_in2, zpu_in3, cart_ready,
      output zpu_out2, zpu_out3, zpu_wr, zpu_rd,
             cart_addr, cart_data, cart_valid, busy, done, error
   );

   modport slave (
      output zpu_in2, zpu_in3, cart_ready,
      input  zpu_out2, zpu_out3, zpu_wr, zpu_rd,
             cart_addr, cart_data, cart_valid, busy, done, error
   );
endinterface

// File: rtl/cart_block_loader.sv
// cart_block_loader: streams a mounted file from the ZPU SD bridge into cart RAM,
// one 512-byte sector at a time, starting whenever the mounted bit toggles.
// Optional macro CART_LOADER_TIMEOUT_EN adds an io_done watchdog (TMO_CYC cycles).
module cart_block_loader
   import cart_loader_pkg::*;
#(
   parameter int          ADDR_W  = 19,
   parameter logic [23:0] TMO_CYC = 24'd16777215
) (
   input  logic                clk_sys,
   input  logic                reset,
   cart_block_loader_if.master bus
);

   localparam int CW = ADDR_W + 1;
   localparam logic [CW-1:0]     ONE_C = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [8:0]        LAST_IDX = 9'(SECTOR_BYTES - 1);

   logic [3:0]        state;
   logic [2:0]        cyc;       // cycle count within the current state
   logic [31:0]       sector;
   logic [8:0]        bidx;      // byte index within the current sector
   logic [CW-1:0]     count;     // bytes handed to cart RAM so far
   logic [CW-1:0]     size;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        data;
   logic              mnt_old;
   logic              blk_low;   // io_done seen low since block_rd was raised

   logic io_done;
   assign io_done = bus.zpu_in2[0];

`ifdef CART_LOADER_TIMEOUT_EN
   logic [23:0] tmo;
`else
   logic unused_tmo;
   assign unused_tmo = ^TMO_CYC;
`endif

   logic unused_sts;
   assign unused_sts = ^bus.zpu_in2[7:2];

   // Load sequencer: size query, per-sector LBA/read/reset, then byte-by-byte streaming
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         cyc     <= 3'd0;
         sector  <= 32'd0;
         bidx    <= 9'd0;
         count   <= '0;
         size    <= '0;
         addr    <= '0;
         data    <= 8'd0;
         mnt_old <= 1'b0;
         blk_low <= 1'b0;
`ifdef CART_LOADER_TIMEOUT_EN
         tmo     <= 24'd0;
`endif
      end else begin
         // Tracked every cycle so toggles during a load are swallowed rather than queued
         mnt_old <= bus.zpu_in2[1];
         case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (bus.zpu_in2[1] != mnt_old) begin
                  state  <= ST_SIZE;
                  cyc    <= 3'd0;
                  sector <= 32'd0;
                  bidx   <= 9'd0;
                  count  <= '0;
                  addr   <= '0;
               end
            end
            ST_SIZE: begin
               if (cyc == 3'd1) begin
                  cyc <= 3'd0;
                  if (size_ok(bus.zpu_in3, ADDR_W)) begin
                     size  <= bus.zpu_in3[ADDR_W:0];
                     state <= ST_LBA;
                  end else begin
                     state <= ST_ERR;
                  end
               end else begin
                  cyc <= cyc + 3'd1;
               end
            end
            ST_LBA: begin
               if (cyc == 3'd4) begin
                  cyc     <= 3'd0;
                  blk_low <= 1'b0;
                  state   <= ST_BLK;
`ifdef CART_LOADER_TIMEOUT_EN
                  tmo     <= 24'd0;
`endif
               end else begin
                  cyc <= cyc + 3'd1;
               end
            end
            ST_BLK: begin
               if (!io_done) blk_low <= 1'b1;
               if (blk_low && io_done) begin
                  state <= ST_RST;
               end
`ifdef CART_LOADER_TIMEOUT_EN
               else if (tmo >= TMO_CYC) begin
                  state <= ST_ERR;
               end else begin
                  tmo <= tmo + 24'd1;
               end
`endif
            end
            ST_RST: begin
               cyc   <= 3'd0;
               state <= ST_RD;
            end
            ST_RD: begin
               // Buffer RAM has one cycle of latency: data is valid on the second strobe cycle
               if (cyc == 3'd1) begin
                  cyc   <= 3'd0;
                  data  <= bus.zpu_in3[7:0];
                  state <= (count < size) ? ST_PRES : ST_GAP;
               end else begin
                  cyc <= cyc + 3'd1;
               end
            end
            ST_PRES: begin
               if (bus.cart_ready) begin
                  count <= count + ONE_C;
                  // Stop on the last byte so the address never wraps at full image size
                  if ((count + ONE_C) < size) addr <= addr + ONE_A;
                  cyc   <= 3'd0;
                  state <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (cyc == 3'd1) begin
                  cyc <= 3'd0;
                  if (bidx == LAST_IDX) begin
                     bidx <= 9'd0;
                     if (count < size) begin
                        sector <= sector + 32'd1;
                        state  <= ST_LBA;
                     end else begin
                        state  <= ST_DONE;
                     end
                  end else begin
                     bidx  <= bidx + 9'd1;
                     state <= ST_RD;
                  end
               end else begin
                  cyc <= cyc + 3'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Bridge strobes, cart stream and status decoded straight from the state register
   always_comb begin
      bus.zpu_out2 = 32'd0;
      bus.zpu_wr   = 16'd0;
      bus.zpu_rd   = 16'd0;
      bus.zpu_out3 = sector;
      bus.zpu_out2[LBA_SEL] = (state == ST_SIZE) || (state == ST_LBA);
      bus.zpu_out2[BLK_RD]  = (state == ST_BLK);
      bus.zpu_wr[DATA_WR]   = (state == ST_LBA) && (cyc < 3'd3);
      bus.zpu_wr[IO_WR]     = (state == ST_RST);
      bus.zpu_rd[DATA_RD]   = (state == ST_RD);
      bus.cart_addr  = addr;
      bus.cart_data  = data;
      bus.cart_valid = (state == ST_PRES);
      bus.done       = (state == ST_DONE);
      bus.error      = (state == ST_ERR);
      bus.busy       = !((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
   end

endmodule

// File: tb/tb_cart_block_loader.sv
// tb_cart_block_loader: bridge/SD model plus scoreboard for cart_block_loader.
module tb_cart_block_loader;
   import cart_loader_pkg::*;

   localparam int ADDR_W = 19;
`ifdef CART_LOADER_TIMEOUT_EN
   localparam logic [23:0] TMO = 24'd100;
`else
   localparam logic [23:0] TMO = 24'd16777215;
`endif

   logic clk_sys = 1'b0;
   logic reset   = 1'b1;
   always #5 clk_sys = ~clk_sys;

   cart_block_loader_if #(.ADDR_W(ADDR_W)) bus();

   cart_block_loader #(.ADDR_W(ADDR_W), .TMO_CYC(TMO)) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .bus     (bus)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] pat(input int lba, input int idx);
      int v;
      v = lba * 53 + idx * 7 + (idx >> 3);
      return v[7:0] ^ 8'h5A;
   endfunction

   // ---------------- bridge model ----------------
   logic [7:0]  mem [512];
   logic [7:0]  buf_q      = 8'd0;
   logic [8:0]  bptr       = 9'd0;
   logic        io_done    = 1'b1;
   logic        never_done = 1'b0;
   logic        mnt        = 1'b0;
   logic [31:0] fsize      = 32'd0;
   logic [31:0] lba_q      = 32'd0;
   logic        blk_prev = 1'b0, rd_prev = 1'b0, wr6_prev = 1'b0;
   int          dly = 0;

   initial for (int i = 0; i < 512; i++) mem[i] = 8'd0;

   assign bus.zpu_in2 = {6'd0, mnt, io_done};
   assign bus.zpu_in3 = bus.zpu_out2[0] ? fsize : {24'd0, buf_q};

   always @(posedge clk_sys) begin
      blk_prev <= bus.zpu_out2[1];
      rd_prev  <= bus.zpu_rd[2];
      wr6_prev <= bus.zpu_wr[6];
      buf_q    <= mem[bptr];
      if (bus.zpu_wr[6] && !wr6_prev && bus.zpu_out2[0]) lba_q <= bus.zpu_out3;
      if (bus.zpu_wr[5]) bptr <= 9'd0;
      else if (rd_prev && !bus.zpu_rd[2]) bptr <= bptr + 9'd1;
      if (bus.zpu_out2[1] && !blk_prev) begin
         io_done <= 1'b0;
         dly     <= 20;
      end else if (!io_done && !never_done) begin
         if (dly == 0) begin
            for (int i = 0; i < 512; i++) mem[i] <= pat(int'(lba_q), i);
            io_done <= 1'b1;
         end else begin
            dly <= dly - 1;
         end
      end
   end

   // ---------------- scoreboard / monitor ----------------
   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [7:0]        d;
   } exp_t;
   exp_t exp_q [$];
   int   lba_exp [$];

   int n_xfer = 0, n_rd = 0, n_blk = 0;
   logic [ADDR_W-1:0] last_addr = '0;
   logic rd_pn = 1'b0, blk_pn = 1'b0, wr6_pn = 1'b0;

   always @(negedge clk_sys) begin
      exp_t e;
      int   l;
      if (bus.cart_valid && bus.cart_ready) begin
         if (exp_q.size() == 0) begin
            check("extra_byte", 64'(bus.cart_addr), 64'(0));
         end else begin
            e = exp_q.pop_front();
            check("cart_addr", 64'(bus.cart_addr), 64'(e.a));
            check("cart_data", 64'(bus.cart_data), 64'(e.d));
         end
         n_xfer++;
         last_addr = bus.cart_addr;
      end
      if (bus.zpu_rd[2] && !rd_pn) n_rd++;
      if (bus.zpu_out2[1] && !blk_pn) n_blk++;
      if (bus.zpu_wr[6] && !wr6_pn) begin
         if (lba_exp.size() == 0) begin
            check("extra_lba", 64'(bus.zpu_out3), 64'(0));
         end else begin
            l = lba_exp.pop_front();
            check("lba_value", 64'(bus.zpu_out3), 64'(l));
            check("lba_sel", 64'(bus.zpu_out2[0]), 64'(1));
         end
      end
      rd_pn  = bus.zpu_rd[2];
      blk_pn = bus.zpu_out2[1];
      wr6_pn = bus.zpu_wr[6];
   end

   task automatic push_exp(input int size);
      exp_t e;
      for (int i = 0; i < size; i++) begin
         e.a = ADDR_W'(i);
         e.d = pat(i / 512, i % 512);
         exp_q.push_back(e);
      end
      for (int s = 0; s < (size + 511) / 512; s++) lba_exp.push_back(s);
   endtask

   task automatic start_load(input int size, input bit valid);
      n_xfer = 0; n_rd = 0; n_blk = 0;
      if (valid) push_exp(size);
      @(posedge clk_sys); #1;
      fsize = 32'(size);
      mnt   = ~mnt;
      repeat (2) @(posedge clk_sys);
      #1;
   endtask

   task automatic wait_end(input int budget);
      int k = 0;
      while (!(bus.done || bus.error) && k < budget) begin
         @(posedge clk_sys); #1;
         k++;
      end
      if (k >= budget) check("wait_end_budget", 64'(k), 64'(0));
   endtask

   task automatic stall_at_10();
      int   k;
      logic [7:0] held;
      int   bad_d = 0, bad_rd = 0, bad_v = 0;
      k = 0;
      while (n_xfer < 10 && k < 20000) begin
         @(posedge clk_sys); #1; k++;
      end
      bus.cart_ready = 1'b0;
      k = 0;
      while (!bus.cart_valid && k < 50) begin
         @(posedge clk_sys); #1; k++;
      end
      check("stall_valid_seen", 64'(bus.cart_valid), 64'(1));
      held = bus.cart_data;
      check("stall_byte10", 64'(held), 64'(pat(0, 10)));
      repeat (50) begin
         @(negedge clk_sys);
         if (bus.cart_data !== held) bad_d++;
         if (bus.zpu_rd[2] !== 1'b0) bad_rd++;
         if (bus.cart_valid !== 1'b1) bad_v++;
      end
      check("stall_data_stable", 64'(bad_d), 64'(0));
      check("stall_no_rd", 64'(bad_rd), 64'(0));
      check("stall_valid_held", 64'(bad_v), 64'(0));
      @(posedge clk_sys); #1;
      bus.cart_ready = 1'b1;
   endtask

   initial begin
      bus.cart_ready = 1'b1;
      // Reset state
      #12;
      check("rst_out2", 64'(bus.zpu_out2), 64'(0));
      check("rst_out3", 64'(bus.zpu_out3), 64'(0));
      check("rst_strobes", 64'({bus.zpu_wr, bus.zpu_rd}), 64'(0));
      check("rst_cart", 64'({bus.cart_valid, bus.cart_addr, bus.cart_data}), 64'(0));
      check("rst_status", 64'({bus.busy, bus.done, bus.error}), 64'(0));
      @(posedge clk_sys); #1;
      reset = 1'b0;
      repeat (5) @(posedge clk_sys);
      #1;
      check("idle_no_start", 64'(bus.busy), 64'(0));

      // Full two-sector image
      start_load(1024, 1'b1);
      check("busy_during_load", 64'(bus.busy), 64'(1));
      wait_end(20000);
      check("t1024_done", 64'(bus.done), 64'(1));
      check("t1024_error", 64'(bus.error), 64'(0));
      check("t1024_busy", 64'(bus.busy), 64'(0));
      check("t1024_bytes", 64'(n_xfer), 64'(1024));
      check("t1024_last_addr", 64'(last_addr), 64'(1023));
      check("t1024_reads", 64'(n_rd), 64'(1024));
      check("t1024_sb_empty", 64'(exp_q.size()), 64'(0));
      check("t1024_lba_empty", 64'(lba_exp.size()), 64'(0));

      // Partial last sector with a ready stall at byte 10
      start_load(700, 1'b1);
      fork
         wait_end(20000);
         stall_at_10();
      join
      check("t700_done", 64'(bus.done), 64'(1));
      check("t700_bytes", 64'(n_xfer), 64'(700));
      check("t700_last_addr", 64'(last_addr), 64'(699));
      check("t700_reads", 64'(n_rd), 64'(1024));
      check("t700_sb_empty", 64'(exp_q.size()), 64'(0));
      check("t700_lba_empty", 64'(lba_exp.size()), 64'(0));

      // Empty file
      start_load(0, 1'b0);
      wait_end(100);
      check("t0_error", 64'(bus.error), 64'(1));
      check("t0_done", 64'(bus.done), 64'(0));
      check("t0_no_blk", 64'(n_blk), 64'(0));

      // One byte too large
      start_load((1 << ADDR_W) + 1, 1'b0);
      wait_end(100);
      check("tbig_error", 64'(bus.error), 64'(1));
      check("tbig_no_blk", 64'(n_blk), 64'(0));
      check("tbig_busy", 64'(bus.busy), 64'(0));

      // Reset in the middle of a load, then restart because mounted stays 1
      start_load(1024, 1'b1);
      begin
         int k = 0;
         while (n_xfer < 300 && k < 20000) begin
            @(posedge clk_sys); #1; k++;
         end
         check("t300_reached", 64'(n_xfer), 64'(300));
      end
      reset = 1'b1;
      @(negedge clk_sys);
      check("mid_rst_out2", 64'(bus.zpu_out2), 64'(0));
      check("mid_rst_strobes", 64'({bus.zpu_wr, bus.zpu_rd}), 64'(0));
      check("mid_rst_status", 64'({bus.busy, bus.cart_valid}), 64'(0));
      exp_q.delete();
      lba_exp.delete();
      repeat (3) @(posedge clk_sys);
      #1;
      n_xfer = 0; n_rd = 0; n_blk = 0;
      push_exp(1024);
      reset = 1'b0;
      repeat (3) @(posedge clk_sys);
      #1;
      check("restart_busy", 64'(bus.busy), 64'(1));
      wait_end(20000);
      check("restart_done", 64'(bus.done), 64'(1));
      check("restart_bytes", 64'(n_xfer), 64'(1024));
      check("restart_sb_empty", 64'(exp_q.size()), 64'(0));
      check("restart_lba_empty", 64'(lba_exp.size()), 64'(0));

`ifdef CART_LOADER_TIMEOUT_EN
      // io_done never returns
      never_done = 1'b1;
      start_load(1024, 1'b0);
      lba_exp.push_back(0);
      begin
         int k = 0;
         int c = 0;
         while (!bus.zpu_out2[1] && k < 100) begin
            @(posedge clk_sys); #1; k++;
         end
         while (!bus.error && c < 400) begin
            @(posedge clk_sys); #1; c++;
         end
         check("tmo_error", 64'(bus.error), 64'(1));
         check("tmo_blk_dropped", 64'(bus.zpu_out2[1]), 64'(0));
         check("tmo_window", 64'((c >= 95) && (c <= 110)), 64'(1));
      end
      lba_exp.delete();
      never_done = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/cart_block_loader.md
CART_BLOCK_LOADER -- requirements
Module: cart_block_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 19: width of the cart byte address and of the maximum image size (2^ADDR_W bytes).
REQ-002 SHALL have parameter TMO_CYC, default 24'd16777215: io_done watchdog limit in clk_sys cycles (used only under the macro).
REQ-003 clk_sys  in  1  single clock for all logic.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 zpu_in2  in  8  bridge status: [0] io_done, [1] mounted (toggle), [4:2] fileno, [6:5] filetype, [7] readonly.
REQ-006 zpu_in3  in  32  bridge data: file size when out2[0]=1, else buffer byte in [7:0].
REQ-007 zpu_out2  out  32  control: [0] lba_sel, [1] block_rd, [2] block_wr (tied 0); others 0.
REQ-008 zpu_out3  out  32  LBA value.
REQ-009 zpu_wr  out  16  write strobes: [5] io_wr (buffer address reset), [6] data_wr; others 0.
REQ-010 zpu_rd  out  16  read strobes: [2] data_rd; others 0.
REQ-011 cart_addr, cart_data, cart_valid, cart_ready  out ADDR_W / out 8 / out 1 / in 1  byte stream to cart RAM; a byte transfers when valid & ready.
REQ-012 busy, done, error  out  1 each  load status.

Function
REQ-013 SHALL start a load on any change of zpu_in2[1] (old value resets to 0) while in IDLE, DONE or ERR; changes while busy are ignored.
REQ-014 SIZE state: drive out2[0]=1 for 2 cycles, then latch zpu_in3 as size; size==0 or size>2^ADDR_W -> ERR.
REQ-015 LBA state: out3=sector, out2[0]=1, wr[6] high 3 cycles, then low 2 cycles (bridge edge detect requires >=2 high cycles).
REQ-016 BLK state: drop out2[0], raise out2[1]; wait for io_done==0 then io_done==1; drop out2[1] on completion.
REQ-017 RST state: wr[5] high 1 cycle to zero the bridge buffer address.
REQ-018 Byte read: rd[2] high; sample zpu_in3[7:0] on the 2nd high cycle (1-cycle RAM latency); drop rd[2]; 2 idle cycles before next read.
REQ-019 Sampled byte SHALL be held on cart_data with cart_valid=1 until cart_ready; cart_addr increments by 1 after each transfer.
REQ-020 After 512 bytes or byte count==size: more bytes -> sector+1 -> LBA; else DONE.
REQ-021 Last sector SHALL still be fetched whole; bytes beyond size are read but not presented.
REQ-022 DONE: done=1, busy=0 until next load start; ERR: error=1 likewise.
REQ-023 cart_addr SHALL never wrap: count bounded by REQ-014 check.
REQ-024 busy=1 in all states except IDLE, DONE, ERR.

Reset
REQ-025 On reset: state IDLE; all outputs 0; sector, count, size, old mounted 0; reset mid-load aborts with no further strobes.
REQ-026 If mounted==1 after reset release, a load SHALL start (old mounted=0).

Configuration
REQ-027 Macro CART_LOADER_TIMEOUT_EN: when defined, a counter in BLK wait exceeding TMO_CYC -> drop out2[1], ERR; when undefined, BLK waits indefinitely and TMO_CYC is unused.

Structure
REQ-028 Package cart_loader_pkg SHALL hold the state enum, SECTOR_BYTES=512, strobe bit indices (LBA_SEL=0, BLK_RD=1, IO_WR=5, DATA_WR=6, DATA_RD=2).
REQ-029 Single module; watchdog counter inline, no sub-module.

Verification
REQ-030 Bridge model, size=1024, mount toggle -> LBA writes 0 then 1, 1024 bytes, cart_addr 0..1023, done=1.
REQ-031 size=700 -> 2 sectors fetched, exactly 700 bytes presented, last cart_addr=699.
REQ-032 cart_ready held low 50 cycles at byte 10 -> cart_data stable, no rd[2] pulse until accepted.
REQ-033 size=0 -> error=1, no block_rd; size=2^19+1 -> error=1.
REQ-034 reset pulsed at byte 300 -> all strobes 0 next cycle; mounted=1 after release -> load restarts at LBA 0.
REQ-035 With CART_LOADER_TIMEOUT_EN, TMO_CYC=100, io_done never returns -> error=1 at cycle ~100 and out2[1]=0.
